// File: rtl/mips_interrupt_controller.sv
// mips_interrupt_controller
//
// Collects N_IRQ external interrupt lines, keeps per-source pending/mask/edge
// state, and presents the highest-priority enabled source to COPROCESSOR0 as a
// single request with a handler vector. Each request runs IDLE -> REQ ->
// SERVICE -> IDLE (request, acknowledge, ERET). There is no nesting.
//
// Ports:
//   i_clk              clock, all state on rising edge
//   i_rst              synchronous active-high reset
//   i_irq              raw interrupt lines (asynchronous to i_clk)
//   i_global_ie        COPROCESSOR0 status IE bit
//   i_cfg_we           register write strobe
//   i_cfg_addr         0 MASK, 1 EDGE, 2 PENDING (write-1-to-clear), 3 VBASE
//   i_cfg_wdata        write data
//   o_cfg_rdata        combinational read data for i_cfg_addr
//   o_int_req          interrupt request to COPROCESSOR0
//   o_int_id           id of the requested source
//   o_handler_address  VBASE + (id << VECTOR_STRIDE_LOG2), latched with the id
//   i_int_ack          COPROCESSOR0 took the exception (one-cycle pulse)
//   i_eret             handler executed ERET (one-cycle pulse)
//   o_in_service       high while a handler runs
module mips_interrupt_controller #(
  parameter int unsigned N_IRQ              = 8,
  parameter logic [31:0] VECTOR_BASE        = 32'h0000_0024,
  parameter int unsigned VECTOR_STRIDE_LOG2 = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_IRQ-1:0] i_irq,
  input  logic             i_global_ie,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_addr,
  input  logic [31:0]      i_cfg_wdata,
  output logic [31:0]      o_cfg_rdata,
  output logic             o_int_req,
  output logic [4:0]       o_int_id,
  output logic [31:0]      o_handler_address,
  input  logic             i_int_ack,
  input  logic             i_eret,
  output logic             o_in_service
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StService
  } state_e;

  localparam logic [1:0] AddrMask    = 2'd0;
  localparam logic [1:0] AddrEdge    = 2'd1;
  localparam logic [1:0] AddrPending = 2'd2;
  localparam logic [1:0] AddrVbase   = 2'd3;

  state_e state_q, state_d;

  logic [N_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [N_IRQ-1:0] mask_q, edge_q, pending_q, pending_d;
  logic [31:0]      vbase_q;
  logic [4:0]       int_id_q;
  logic [31:0]      handler_addr_q;

  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] cur_sel;    // one-hot of the latched id
  logic [N_IRQ-1:0] w1c;
  logic [N_IRQ-1:0] ack_clr;
  logic [4:0]       winner;
  logic             any_eligible;
  logic             cur_eligible;
  logic             latch_req;
  logic             ack_take;

  // Priority pick: lowest set index wins.
  always_comb begin
    eligible     = pending_q & mask_q;
    any_eligible = |eligible;
    winner       = '0;
    cur_sel      = '0;
    for (int i = 0; i < int'(N_IRQ); i++) begin
      if (eligible[i] && (winner == '0) && !eligible[0]) begin
        // first set bit above index 0; index 0 leaves winner at 0
        winner = 5'(i);
      end
      cur_sel[i] = (int_id_q == 5'(i));
    end
    cur_eligible = |(eligible & cur_sel);
  end

  // Request sequencing.
  always_comb begin
    state_d   = state_q;
    latch_req = 1'b0;
    ack_take  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_eligible && i_global_ie) begin
          state_d   = StReq;
          latch_req = 1'b1;
        end
      end
      StReq: begin
        // Ack beats withdrawal when both happen in one cycle.
        if (i_int_ack) begin
          state_d  = StService;
          ack_take = 1'b1;
        end else if (!i_global_ie || !cur_eligible) begin
          state_d = StIdle;
        end
      end
      StService: begin
        if (i_eret) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Edge sources: set beats clear. Level sources just track the synchronised line.
  always_comb begin
    w1c       = (i_cfg_we && (i_cfg_addr == AddrPending)) ? i_cfg_wdata[N_IRQ-1:0] : '0;
    ack_clr   = ack_take ? cur_sel : '0;
    pending_d = (edge_q & ((s2_q & ~s3_q) | (pending_q & ~(w1c | ack_clr))))
              | (~edge_q & s2_q);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q        <= StIdle;
      s1_q           <= '0;
      s2_q           <= '0;
      s3_q           <= '0;
      mask_q         <= '0;
      edge_q         <= '0;
      pending_q      <= '0;
      vbase_q        <= VECTOR_BASE;
      int_id_q       <= '0;
      handler_addr_q <= VECTOR_BASE;
    end else begin
      state_q   <= state_d;
      s1_q      <= i_irq;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      pending_q <= pending_d;
      if (i_cfg_we && (i_cfg_addr == AddrMask)) begin
        mask_q <= i_cfg_wdata[N_IRQ-1:0];
      end
      if (i_cfg_we && (i_cfg_addr == AddrEdge)) begin
        edge_q <= i_cfg_wdata[N_IRQ-1:0];
      end
      if (i_cfg_we && (i_cfg_addr == AddrVbase)) begin
        vbase_q <= i_cfg_wdata;
      end
      // Vector is captured with the id so later VBASE writes leave it alone.
      if (latch_req) begin
        int_id_q       <= winner;
        handler_addr_q <= vbase_q + (32'(winner) << VECTOR_STRIDE_LOG2);
      end
    end
  end

  always_comb begin
    o_cfg_rdata = '0;
    unique case (i_cfg_addr)
      AddrMask:    o_cfg_rdata = 32'(mask_q);
      AddrEdge:    o_cfg_rdata = 32'(edge_q);
      AddrPending: o_cfg_rdata = 32'(pending_q);
      AddrVbase:   o_cfg_rdata = vbase_q;
      default:     o_cfg_rdata = '0;
    endcase
  end

  assign o_int_req         = (state_q == StReq);
  assign o_in_service      = (state_q == StService);
  assign o_int_id          = int_id_q;
  assign o_handler_address = handler_addr_q;

  // Write data above N_IRQ only matters for VBASE.
  if (N_IRQ < 32) begin : g_unused
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^i_cfg_wdata[31:N_IRQ];
  end

endmodule

// File: tb/tb_mips_interrupt_controller.sv
module tb_mips_interrupt_controller;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [7:0]  i_irq;
  logic        i_global_ie;
  logic        i_cfg_we;
  logic [1:0]  i_cfg_addr;
  logic [31:0] i_cfg_wdata;
  logic [31:0] o_cfg_rdata;
  logic        o_int_req;
  logic [4:0]  o_int_id;
  logic [31:0] o_handler_address;
  logic        i_int_ack;
  logic        i_eret;
  logic        o_in_service;

  always #5 i_clk = ~i_clk;

  mips_interrupt_controller #(
    .N_IRQ             (8),
    .VECTOR_BASE       (32'h0000_0024),
    .VECTOR_STRIDE_LOG2(3)
  ) dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_irq            (i_irq),
    .i_global_ie      (i_global_ie),
    .i_cfg_we         (i_cfg_we),
    .i_cfg_addr       (i_cfg_addr),
    .i_cfg_wdata      (i_cfg_wdata),
    .o_cfg_rdata      (o_cfg_rdata),
    .o_int_req        (o_int_req),
    .o_int_id         (o_int_id),
    .o_handler_address(o_handler_address),
    .i_int_ack        (i_int_ack),
    .i_eret           (i_eret),
    .o_in_service     (o_in_service)
  );

  // Expected outputs just after the clock edge that consumes a vector.
  typedef struct {
    logic        req;
    logic [4:0]  id;
    logic [31:0] ha;
    logic        svc;
    logic        rchk;
    logic [31:0] rexp;
  } exp_t;

  typedef struct {
    logic [7:0]  irq;
    logic        ie;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        eret;
    logic        rst;
    exp_t        e;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step_no = 0;

  function automatic exp_t mk_exp(logic req, logic [4:0] id, logic [31:0] ha, logic svc,
                                  logic rchk, logic [31:0] rexp);
    exp_t e;
    e.req = req; e.id = id; e.ha = ha; e.svc = svc; e.rchk = rchk; e.rexp = rexp;
    return e;
  endfunction

  function automatic void add(int n, logic [7:0] irq, logic ie, logic we, logic [1:0] addr,
                              logic [31:0] wd, logic ack, logic eret, logic rst, logic req,
                              logic [4:0] id, logic [31:0] ha, logic svc, logic rchk,
                              logic [31:0] rexp);
    vec_t v;
    v.irq = irq; v.ie = ie; v.we = we; v.addr = addr; v.wdata = wd;
    v.ack = ack; v.eret = eret; v.rst = rst;
    v.e = mk_exp(req, id, ha, svc, rchk, rexp);
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, want);
    end
  endtask

  // Push expectation, clock once, then pop and compare against the DUT.
  task automatic step(input exp_t e);
    exp_t g;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    g = exp_q.pop_front();
    check("int_req", 32'(o_int_req), 32'(g.req));
    check("int_id", 32'(o_int_id), 32'(g.id));
    check("handler_address", o_handler_address, g.ha);
    check("in_service", 32'(o_in_service), 32'(g.svc));
    if (g.rchk) check("cfg_rdata", o_cfg_rdata, g.rexp);
    step_no++;
  endtask

  task automatic apply(input vec_t v);
    i_irq = v.irq; i_global_ie = v.ie; i_cfg_we = v.we; i_cfg_addr = v.addr;
    i_cfg_wdata = v.wdata; i_int_ack = v.ack; i_eret = v.eret; i_rst = v.rst;
    step(v.e);
  endtask

  initial begin
    i_rst = 1'b1; i_irq = '0; i_global_ie = 1'b0; i_cfg_we = 1'b0; i_cfg_addr = '0;
    i_cfg_wdata = '0; i_int_ack = 1'b0; i_eret = 1'b0;

    //  n  irq   ie we ad wdata ack ert rst  req id ha     svc rchk rexp
    // reset, MASK=1, EDGE=0, level source 0
    add(1, 8'h00, 0, 0, 3, 0,     0, 0, 1,   0, 0, 32'h24, 0, 1, 32'h24);
    add(1, 8'h00, 1, 1, 0, 1,     0, 0, 0,   0, 0, 32'h24, 0, 1, 32'h01);
    add(1, 8'h00, 1, 1, 1, 0,     0, 0, 0,   0, 0, 32'h24, 0, 1, 32'h00);
    add(3, 8'h01, 1, 0, 0, 0,     0, 0, 0,   0, 0, 32'h24, 0, 0, 0);
    add(1, 8'h01, 1, 0, 0, 0,     0, 0, 0,   1, 0, 32'h24, 0, 0, 0);
    add(1, 8'h01, 1, 0, 0, 0,     1, 0, 0,   0, 0, 32'h24, 1, 0, 0);
    add(1, 8'h01, 1, 0, 0, 0,     0, 0, 0,   0, 0, 32'h24, 1, 0, 0);
    add(1, 8'h01, 1, 0, 0, 0,     0, 1, 0,   0, 0, 32'h24, 0, 0, 0);
    add(1, 8'h00, 1, 0, 0, 0,     0, 0, 0,   1, 0, 32'h24, 0, 0, 0);
    add(1, 8'h00, 1, 0, 0, 0,     1, 0, 0,   0, 0, 32'h24, 1, 0, 0);
    add(1, 8'h00, 1, 0, 0, 0,     0, 1, 0,   0, 0, 32'h24, 0, 0, 0);
    add(1, 8'h00, 1, 0, 2, 0,     0, 0, 0,   0, 0, 32'h24, 0, 1, 32'h00);
    // all edge, all enabled: lines 5 and 2 together
    add(1, 8'h00, 1, 1, 0, 8'hFF, 0, 0, 0,   0, 0, 32'h24, 0, 1, 32'hFF);
    add(1, 8'h00, 1, 1, 1, 8'hFF, 0, 0, 0,   0, 0, 32'h24, 0, 1, 32'hFF);
    add(3, 8'h24, 1, 0, 0, 0,     0, 0, 0,   0, 0, 32'h24, 0, 0, 0);
    add(1, 8'h24, 1, 0, 0, 0,     0, 0, 0,   1, 2, 32'h34, 0, 0, 0);
    add(1, 8'h24, 1, 0, 2, 0,     1, 0, 0,   0, 2, 32'h34, 1, 1, 32'h20);
    add(1, 8'h24, 1, 0, 0, 0,     0, 1, 0,   0, 2, 32'h34, 0, 0, 0);
    add(1, 8'h24, 1, 0, 0, 0,     0, 0, 0,   1, 5, 32'h4C, 0, 0, 0);
    add(1, 8'h24, 1, 0, 2, 0,     1, 0, 0,   0, 5, 32'h4C, 1, 1, 32'h00);
    add(1, 8'h00, 1, 0, 0, 0,     0, 1, 0,   0, 5, 32'h4C, 0, 0, 0);
    add(1, 8'h00, 1, 0, 0, 0,     0, 0, 0,   0, 5, 32'h4C, 0, 0, 0);
    // REQ for id 5, then line 1 arrives: no preemption
    add(3, 8'h20, 1, 0, 0, 0,     0, 0, 0,   0, 5, 32'h4C, 0, 0, 0);
    add(1, 8'h20, 1, 0, 0, 0,     0, 0, 0,   1, 5, 32'h4C, 0, 0, 0);
    add(4, 8'h22, 1, 0, 0, 0,     0, 0, 0,   1, 5, 32'h4C, 0, 0, 0);
    add(1, 8'h22, 1, 0, 0, 0,     1, 0, 0,   0, 5, 32'h4C, 1, 0, 0);
    add(1, 8'h22, 1, 0, 0, 0,     0, 1, 0,   0, 5, 32'h4C, 0, 0, 0);
    add(1, 8'h22, 1, 0, 0, 0,     0, 0, 0,   1, 1, 32'h2C, 0, 0, 0);
    add(1, 8'h22, 1, 0, 0, 0,     1, 0, 0,   0, 1, 32'h2C, 1, 0, 0);
    add(1, 8'h22, 1, 0, 0, 0,     0, 1, 0,   0, 1, 32'h2C, 0, 0, 0);
    add(1, 8'h22, 1, 0, 2, 0,     0, 0, 0,   0, 1, 32'h2C, 0, 1, 32'h00);
    // IE withdrawal and reissue; ack beats withdrawal
    add(3, 8'h2A, 1, 0, 0, 0,     0, 0, 0,   0, 1, 32'h2C, 0, 0, 0);
    add(1, 8'h2A, 1, 0, 0, 0,     0, 0, 0,   1, 3, 32'h3C, 0, 0, 0);
    add(2, 8'h2A, 0, 0, 0, 0,     0, 0, 0,   0, 3, 32'h3C, 0, 0, 0);
    add(1, 8'h2A, 1, 0, 0, 0,     0, 0, 0,   1, 3, 32'h3C, 0, 0, 0);
    add(1, 8'h2A, 0, 0, 0, 0,     1, 0, 0,   0, 3, 32'h3C, 1, 0, 0);
    add(1, 8'h2A, 1, 0, 0, 0,     0, 1, 0,   0, 3, 32'h3C, 0, 0, 0);
    add(1, 8'h2A, 0, 0, 0, 0,     0, 0, 0,   0, 3, 32'h3C, 0, 0, 0);
    // W1C racing a new edge on line 2: set wins; W1C alone clears
    add(2, 8'h2E, 0, 0, 0, 0,     0, 0, 0,   0, 3, 32'h3C, 0, 0, 0);
    add(1, 8'h2E, 0, 0, 2, 0,     0, 0, 0,   0, 3, 32'h3C, 0, 1, 32'h04);
    add(2, 8'h2A, 0, 0, 0, 0,     0, 0, 0,   0, 3, 32'h3C, 0, 0, 0);
    add(2, 8'h2E, 0, 0, 0, 0,     0, 0, 0,   0, 3, 32'h3C, 0, 0, 0);
    add(1, 8'h2E, 0, 1, 2, 4,     0, 0, 0,   0, 3, 32'h3C, 0, 1, 32'h04);
    add(1, 8'h2E, 0, 0, 2, 0,     0, 0, 0,   0, 3, 32'h3C, 0, 1, 32'h04);
    add(1, 8'h2E, 0, 1, 2, 4,     0, 0, 0,   0, 3, 32'h3C, 0, 1, 32'h00);
    add(1, 8'h2E, 1, 0, 0, 0,     0, 0, 0,   0, 3, 32'h3C, 0, 0, 0);

    foreach (vecs[k]) apply(vecs[k]);

    // Reset in the middle of SERVICE, with a relocated VBASE.
    i_irq = 8'h2F; i_global_ie = 1'b1;
    i_cfg_we = 1'b1; i_cfg_addr = 2'd3; i_cfg_wdata = 32'h100;
    step(mk_exp(0, 3, 32'h3C, 0, 1, 32'h100));
    i_cfg_we = 1'b0;
    step(mk_exp(0, 3, 32'h3C, 0, 0, 0));
    step(mk_exp(0, 3, 32'h3C, 0, 0, 0));
    step(mk_exp(1, 0, 32'h100, 0, 0, 0));
    i_int_ack = 1'b1;
    step(mk_exp(0, 0, 32'h100, 1, 0, 0));
    i_int_ack = 1'b0; i_rst = 1'b1;
    step(mk_exp(0, 0, 32'h24, 0, 1, 32'h24));
    i_rst = 1'b0; i_eret = 1'b1; i_cfg_addr = 2'd0;
    step(mk_exp(0, 0, 32'h24, 0, 1, 32'h00));
    i_eret = 1'b0; i_cfg_addr = 2'd2;
    step(mk_exp(0, 0, 32'h24, 0, 1, 32'h00));
    step(mk_exp(0, 0, 32'h24, 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
